// File: rtl/redmule_x_feeder_if.sv
// Stream-in / X-row-out bundle of the RedMulE X feeder.
// The slave modport is the feeder's view; master is the streamer + X buffer side.
interface redmule_x_feeder_if #(
    parameter int unsigned DW = 288
);
    logic [DW-1:0] stream_data_i;
    logic          stream_valid_i;
    logic          stream_ready_o;
    logic          load_o;
    logic [DW-1:0] x_data_o;

    modport slave (
        input  stream_data_i,
        input  stream_valid_i,
        output stream_ready_o,
        output load_o,
        output x_data_o
    );

    modport master (
        output stream_data_i,
        output stream_valid_i,
        input  stream_ready_o,
        input  load_o,
        input  x_data_o
    );
endinterface

// File: rtl/redmule_x_feeder.sv
// X-buffer feeder: beat FIFO plus tile loader, one load per X row, gated by the scheduler ack.
// Optional leftover-element zero masking under `REDMULE_XFEED_LEFTOVER_MASK_EN.
module redmule_x_feeder #(
    parameter int unsigned DW         = 288,
    parameter int unsigned BITW       = 16,
    parameter int unsigned W          = 12,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [$clog2(W):0]           cfg_rows_i,
    input  logic [15:0]                  cfg_tiles_i,
    input  logic [$clog2(DW/BITW):0]     cfg_valid_elems_i,
    input  logic                         rst_w_index_i,
    output logic                         tile_done_o,
    output logic                         job_done_o,
    output logic                         busy_o,
    redmule_x_feeder_if.slave            xif
);
    localparam int unsigned RW = $clog2(W) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {IDLE, FILL, WAIT_ACK} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [RW-1:0]   rows_q, row_cnt_q, rows_cfg;
    logic [TW-1:0]   tiles_q, tile_cnt_q;
    logic [DW-1:0]   head, row_data;
    logic            push, load, tile_done, job_done;
    logic            start_job, row_inc, row_clr, tile_inc;

    assign xif.stream_ready_o = (count_q < CW'(FIFO_DEPTH));
    assign push               = xif.stream_valid_i && xif.stream_ready_o;
    assign head               = mem_q[rd_ptr_q];
    assign rows_cfg           = (cfg_rows_i == '0 || cfg_rows_i > RW'(W)) ? RW'(W) : cfg_rows_i;

    // Beat storage: data path only, no reset needed
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wr_ptr_q] <= xif.stream_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        tile_done = 1'b0;
        job_done  = 1'b0;
        start_job = 1'b0;
        row_inc   = 1'b0;
        row_clr   = 1'b0;
        tile_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && cfg_tiles_i != '0) begin
                    start_job = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (count_q != '0) begin
                    load    = 1'b1;
                    row_inc = 1'b1;
                    if (row_cnt_q == rows_q - RW'(1)) begin
                        row_clr = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (rst_w_index_i) begin
                    tile_done = 1'b1;
                    tile_inc  = 1'b1;
                    if (tile_cnt_q == tiles_q - TW'(1)) begin
                        job_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear in the same cycle suppresses every pulse
        if (clear_i) begin
            load      = 1'b0;
            tile_done = 1'b0;
            job_done  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q     <= '0;
            tiles_q    <= '0;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
        end else if (clear_i) begin
            rows_q     <= '0;
            tiles_q    <= '0;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
        end else begin
            if (start_job) begin
                rows_q     <= rows_cfg;
                tiles_q    <= cfg_tiles_i;
                row_cnt_q  <= '0;
                tile_cnt_q <= '0;
            end
            if (row_clr) begin
                row_cnt_q <= '0;
            end else if (row_inc) begin
                row_cnt_q <= row_cnt_q + RW'(1);
            end
            if (tile_inc) begin
                tile_cnt_q <= tile_cnt_q + TW'(1);
            end
        end
    end

`ifdef REDMULE_XFEED_LEFTOVER_MASK_EN
    localparam int unsigned N_ELEM = DW / BITW;
    localparam int unsigned EW     = $clog2(N_ELEM) + 1;

    logic [EW-1:0] elems_cfg, elems_q;

    assign elems_cfg = (cfg_valid_elems_i == '0 || cfg_valid_elems_i > EW'(N_ELEM))
                     ? EW'(N_ELEM) : cfg_valid_elems_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elems_q <= '0;
        end else if (clear_i) begin
            elems_q <= '0;
        end else if (start_job) begin
            elems_q <= elems_cfg;
        end
    end

    // Zero every element at or beyond the valid element count
    always_comb begin
        row_data = head;
        for (int i = 0; i < int'(N_ELEM); i++) begin
            if (EW'(i) >= elems_q) begin
                row_data[i*BITW +: BITW] = '0;
            end
        end
    end
`else
    logic unused_elems;

    assign unused_elems = ^cfg_valid_elems_i;
    assign row_data     = head;
`endif

    assign xif.load_o   = load;
    assign xif.x_data_o = load ? row_data : '0;
    assign tile_done_o  = tile_done;
    assign job_done_o   = job_done;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_redmule_x_feeder.sv
// Self-checking bench for redmule_x_feeder: directed scenarios plus randomized traffic
// against a transaction-level model (beat queue, rows/tiles remaining).
module tb_redmule_x_feeder;
    localparam int unsigned DW     = 288;
    localparam int unsigned BITW   = 16;
    localparam int unsigned W      = 12;
    localparam int unsigned FD     = 2;
    localparam int unsigned N_ELEM = DW / BITW;
    localparam int unsigned RW     = $clog2(W) + 1;
    localparam int unsigned EW     = $clog2(N_ELEM) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0, start = 1'b0, ack = 1'b0;
    logic [RW-1:0] cfg_rows = '0;
    logic [15:0]   cfg_tiles = '0;
    logic [EW-1:0] cfg_elems = '0;
    logic          tile_done, job_done, busy;

    int errors = 0;
    int checks = 0;

    redmule_x_feeder_if #(.DW(DW)) xif();

    redmule_x_feeder #(.DW(DW), .BITW(BITW), .W(W), .FIFO_DEPTH(FD)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear),
        .start_i           (start),
        .cfg_rows_i        (cfg_rows),
        .cfg_tiles_i       (cfg_tiles),
        .cfg_valid_elems_i (cfg_elems),
        .rst_w_index_i     (ack),
        .tile_done_o       (tile_done),
        .job_done_o        (job_done),
        .busy_o            (busy),
        .xif               (xif.slave)
    );

    initial forever #5 clk = ~clk;

    // Reference model: queued beats and what is left of the current job
    logic [DW-1:0] q[$];
    bit            m_active, m_wait;
    int            m_rows, m_rows_left, m_tiles_left, m_elems;
    logic          e_ready, e_load, e_td, e_jd, e_busy;
    logic [DW-1:0] e_data;
    int            n_loads, n_td, n_jd;

    function automatic logic [DW-1:0] exp_row(input logic [DW-1:0] b, input int elems);
        logic [DW-1:0] r;
        int lim;
        r   = b;
        lim = int'(N_ELEM);
`ifdef REDMULE_XFEED_LEFTOVER_MASK_EN
        lim = elems;
`else
        if (elems < 0) lim = 0;
`endif
        for (int i = 0; i < int'(N_ELEM); i++) if (i >= lim) r[i*BITW +: BITW] = '0;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < int'(DW / 32); i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic model_expect();
        e_ready = (q.size() < int'(FD));
        e_load  = m_active && !m_wait && (q.size() != 0);
        e_td    = m_active && m_wait && ack;
        e_jd    = e_td && (m_tiles_left == 1);
        e_busy  = m_active;
        e_data  = e_load ? exp_row(q[0], m_elems) : '0;
    endtask

    task automatic model_advance();
        bit was_active;
        bit accept;
        was_active = m_active;
        accept     = xif.stream_valid_i && (q.size() < int'(FD));
        if (clear) begin
            q.delete();
            m_active = 0;
            m_wait   = 0;
            return;
        end
        if (e_load) begin
            void'(q.pop_front());
            m_rows_left--;
            if (m_rows_left == 0) m_wait = 1;
        end
        if (e_td) begin
            m_tiles_left--;
            if (m_tiles_left == 0) m_active = 0;
            else begin
                m_wait      = 0;
                m_rows_left = m_rows;
            end
        end
        if (start && !was_active && cfg_tiles != 0) begin
            m_active     = 1;
            m_wait       = 0;
            m_rows       = (cfg_rows == 0 || cfg_rows > W) ? int'(W) : int'(cfg_rows);
            m_rows_left  = m_rows;
            m_tiles_left = int'(cfg_tiles);
            m_elems      = (cfg_elems == 0 || cfg_elems > N_ELEM) ? int'(N_ELEM) : int'(cfg_elems);
        end
        if (accept) q.push_back(xif.stream_data_i);
    endtask

    // Commit model state, tally observed pulses, move to the next drive point
    task automatic next_cycle();
        model_advance();
        n_loads += int'(xif.load_o);
        n_td    += int'(tile_done);
        n_jd    += int'(job_done);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear = 1'b0; start = 1'b0; ack = 1'b0;
        xif.stream_valid_i = 1'b0;
        xif.stream_data_i  = '0;
        cfg_rows = '0; cfg_tiles = '0; cfg_elems = '0;
        q.delete();
        m_active = 0; m_wait = 0; m_rows = 0; m_rows_left = 0; m_tiles_left = 0; m_elems = 0;
        n_loads = 0; n_td = 0; n_jd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            got = {xif.stream_ready_o, xif.load_o, busy, tile_done, job_done, |xif.x_data_o};
            checks++;
            if (got !== 6'b100000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=100000", c, got);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stream();
        int first = -1, twelfth = -1, waitc = 0;
        do_reset();
        cfg_rows = RW'(12); cfg_tiles = 16'd2;
        xif.stream_valid_i = 1'b1;
        for (int c = 0; c < 80; c++) begin
            start = (c == 0);
            xif.stream_data_i = rand_beat();
            waitc = (m_active && m_wait) ? waitc + 1 : 0;
            ack = (waitc == 3);
            #1;
            model_expect();
            checks++;
            if ({xif.stream_ready_o, xif.load_o, tile_done, job_done, busy} !== {e_ready, e_load, e_td, e_jd, e_busy}) begin
                errors++;
                $display("FAIL stream_ctl cyc=%0d got=%b exp=%b", c,
                         {xif.stream_ready_o, xif.load_o, tile_done, job_done, busy}, {e_ready, e_load, e_td, e_jd, e_busy});
            end
            checks++;
            if (xif.x_data_o !== e_data) begin
                errors++;
                $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, xif.x_data_o, e_data);
            end
            if (xif.load_o) begin
                if (first < 0) first = c;
                if (n_loads == 11) twelfth = c;
            end
            next_cycle();
        end
        start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (first !== 1 || twelfth !== 12) begin
            errors++;
            $display("FAIL stream_timing first=%0d twelfth=%0d exp first=1 twelfth=12", first, twelfth);
        end
        checks++;
        if (n_loads !== 24 || n_td !== 2 || n_jd !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_totals loads=%0d td=%0d jd=%0d busy=%b exp 24/2/1/0", n_loads, n_td, n_jd, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy_seq;
        logic [2:0] ld_seq;
        do_reset();
        cfg_rows = RW'(2); cfg_tiles = 16'd1;
        for (int c = 0; c < 14; c++) begin
            xif.stream_valid_i = (c != 2);
            xif.stream_data_i  = rand_beat();
            start = (c == 3);
            ack   = m_active && m_wait;
            #1;
            model_expect();
            checks++;
            if ({xif.stream_ready_o, xif.load_o, tile_done, job_done, busy} !== {e_ready, e_load, e_td, e_jd, e_busy}) begin
                errors++;
                $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", c,
                         {xif.stream_ready_o, xif.load_o, tile_done, job_done, busy}, {e_ready, e_load, e_td, e_jd, e_busy});
            end
            checks++;
            if (xif.x_data_o !== e_data) begin
                errors++;
                $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, xif.x_data_o, e_data);
            end
            if (c >= 2 && c <= 5) rdy_seq[5-c] = xif.stream_ready_o;
            if (c >= 3 && c <= 5) ld_seq[5-c]  = xif.load_o;
            next_cycle();
        end
        start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (rdy_seq !== 4'b0001 || ld_seq !== 3'b011) begin
            errors++;
            $display("FAIL bp_seq ready=%b load=%b exp ready=0001 load=011", rdy_seq, ld_seq);
        end
        checks++;
        if (n_jd !== 1) begin
            errors++;
            $display("FAIL bp_done jobs=%0d exp=1", n_jd);
        end
    endtask

    task automatic test_mask();
        logic [DW-1:0] want;
`ifdef REDMULE_XFEED_LEFTOVER_MASK_EN
        want = {{(DW-80){1'b0}}, {80{1'b1}}};
`else
        want = '1;
`endif
        do_reset();
        cfg_rows = RW'(3); cfg_tiles = 16'd1; cfg_elems = EW'(5);
        xif.stream_valid_i = 1'b1;
        xif.stream_data_i  = '1;
        for (int c = 0; c < 12; c++) begin
            start = (c == 0);
            ack   = m_active && m_wait;
            #1;
            model_expect();
            if (xif.load_o) begin
                checks++;
                if (xif.x_data_o !== want) begin
                    errors++;
                    $display("FAIL mask_data cyc=%0d got=%h exp=%h", c, xif.x_data_o, want);
                end
            end
            next_cycle();
        end
        start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (n_loads !== 3 || n_jd !== 1) begin
            errors++;
            $display("FAIL mask_count loads=%0d jobs=%0d exp 3/1", n_loads, n_jd);
        end
    endtask

    task automatic test_clear();
        logic [2:0] got;
        do_reset();
        cfg_rows = RW'(12); cfg_tiles = 16'd1;
        xif.stream_valid_i = 1'b1;
        for (int c = 0; c < 30 && n_loads < 5; c++) begin
            start = (c == 0);
            xif.stream_data_i = rand_beat();
            #1;
            model_expect();
            checks++;
            if ({xif.stream_ready_o, xif.load_o, busy} !== {e_ready, e_load, e_busy}) begin
                errors++;
                $display("FAIL clr_pre cyc=%0d got=%b exp=%b", c, {xif.stream_ready_o, xif.load_o, busy}, {e_ready, e_load, e_busy});
            end
            next_cycle();
        end
        start = 1'b0;
        clear = 1'b1;
        xif.stream_valid_i = 1'b0;
        #1;
        model_expect();
        next_cycle();
        clear = 1'b0;
        #1;
        got = {busy, xif.stream_ready_o, xif.load_o};
        checks++;
        if (got !== 3'b010 || n_loads !== 5) begin
            errors++;
            $display("FAIL clr_after busy/ready/load=%b loads=%0d exp 010 loads=5", got, n_loads);
        end
        next_cycle();
        n_loads = 0; n_jd = 0;
        cfg_rows = RW'(3);
        xif.stream_valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            xif.stream_data_i = rand_beat();
            ack = m_active && m_wait;
            #1;
            model_expect();
            checks++;
            if (xif.x_data_o !== e_data || xif.load_o !== e_load || job_done !== e_jd) begin
                errors++;
                $display("FAIL clr_job cyc=%0d load=%b jd=%b exp load=%b jd=%b", c, xif.load_o, job_done, e_load, e_jd);
            end
            next_cycle();
        end
        start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (n_loads !== 3 || n_jd !== 1) begin
            errors++;
            $display("FAIL clr_rows3 loads=%0d jobs=%0d exp 3/1", n_loads, n_jd);
        end
    endtask

    task automatic test_clamp();
        int early_td = 0;
        do_reset();
        cfg_rows = RW'(5); cfg_tiles = 16'd0;
        start = 1'b1;
        #1;
        next_cycle();
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clamp_tiles0 busy=%b exp=0", busy);
        end
        next_cycle();
        cfg_rows = RW'(0); cfg_tiles = 16'd1;
        ack = 1'b1;
        xif.stream_valid_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            xif.stream_data_i = rand_beat();
            #1;
            model_expect();
            checks++;
            if ({xif.load_o, tile_done, job_done, busy} !== {e_load, e_td, e_jd, e_busy}) begin
                errors++;
                $display("FAIL clamp_ctl cyc=%0d got=%b exp=%b", c, {xif.load_o, tile_done, job_done, busy}, {e_load, e_td, e_jd, e_busy});
            end
            if (tile_done && n_loads < 12) early_td++;
            next_cycle();
        end
        start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (n_loads !== 12 || n_td !== 1 || early_td !== 0) begin
            errors++;
            $display("FAIL clamp_rows0 loads=%0d td=%0d early_td=%0d exp 12/1/0", n_loads, n_td, early_td);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            xif.stream_valid_i = ($urandom_range(0, 9) < 7);
            xif.stream_data_i  = rand_beat();
            ack       = ($urandom_range(0, 3) == 0);
            start     = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 299) == 0);
            cfg_rows  = RW'($urandom_range(0, 15));
            cfg_tiles = 16'($urandom_range(0, 3));
            cfg_elems = EW'($urandom_range(0, 25));
            #1;
            model_expect();
            if (!clear) begin
                checks++;
                if ({xif.stream_ready_o, xif.load_o, tile_done, job_done, busy} !== {e_ready, e_load, e_td, e_jd, e_busy}) begin
                    errors++;
                    $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c,
                             {xif.stream_ready_o, xif.load_o, tile_done, job_done, busy}, {e_ready, e_load, e_td, e_jd, e_busy});
                end
                checks++;
                if (xif.x_data_o !== e_data) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, xif.x_data_o, e_data);
                end
            end
            next_cycle();
        end
        clear = 1'b0; start = 1'b0; ack = 1'b0; xif.stream_valid_i = 1'b0;
        checks++;
        if (n_jd < 5) begin
            errors++;
            $display("FAIL rand_progress jobs=%0d exp>=5", n_jd);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mask();
        test_clear();
        test_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/redmule_x_feeder.md
# redmule_x_feeder

Upstream stage of the X buffer: accepts DW-bit X beats from the streamer over a valid/ready handshake, stores them in a small FIFO, and issues one `load_o` write pulse per X row into the X buffer until a tile of `cfg_rows_i` rows is loaded. It then waits for the scheduler's row-index reset acknowledgement before loading the next tile. It also zero-masks leftover elements of partial rows so the X buffer sees clean data.

## Interface
- `DW`, 288: beat / X-row width in bits
- `BITW`, 16: element width in bits; `N_ELEM = DW/BITW`
- `W`, 12: max rows per tile (X buffer width)
- `FIFO_DEPTH`, 2: beat FIFO entries, power of two, ≥2
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `clear_i` in 1: synchronous soft clear, same effect as reset
- `start_i` in 1: pulse; samples `cfg_*` and starts a job
- `cfg_rows_i` in `$clog2(W)+1`: rows per tile; 0 or >W means W
- `cfg_tiles_i` in 16: tiles per job; 0 means start ignored
- `cfg_valid_elems_i` in `$clog2(N_ELEM)+1`: valid elements per beat; 0 or >N_ELEM means N_ELEM
- `stream_data_i` in DW: X beat
- `stream_valid_i` in 1: beat valid
- `stream_ready_o` out 1: FIFO can accept
- `load_o` out 1: write X row into buffer this cycle
- `x_data_o` out DW: row data, zero when `load_o`=0
- `rst_w_index_i` in 1: scheduler acknowledge of buffer full, pulse
- `tile_done_o` out 1: pulse, tile acknowledged
- `job_done_o` out 1: pulse, last tile acknowledged
- `busy_o` out 1: state ≠ IDLE

## Operation
- Reset/clear: state IDLE, FIFO empty, counters 0. Output reset values: `stream_ready_o`=1, `load_o`=0, `x_data_o`=0, `tile_done_o`=0, `job_done_o`=0, `busy_o`=0.
- FIFO: push on `stream_valid_i && stream_ready_o`. `stream_ready_o = count < FIFO_DEPTH`, independent of state and of same-cycle pop, so there is no push when full even with a pop. Beats are accepted in IDLE too, so prefetch is allowed.
- FSM states are IDLE, FILL and WAIT_ACK:
  - IDLE → FILL on `start_i` with `cfg_tiles_i`≠0. This cycle latches `rows_q`, `tiles_q`, `elems_q` (clamped) and clears `row_cnt` and `tile_cnt`.
  - FILL: `load_o = (count≠0)`. Each load pops the head and increments `row_cnt`. On the load where `row_cnt == rows_q-1`, go to WAIT_ACK and clear `row_cnt`.
  - WAIT_ACK: `load_o`=0. On `rst_w_index_i`, pulse `tile_done_o` and increment `tile_cnt`. If `tile_cnt == tiles_q-1`, also pulse `job_done_o` and go to IDLE; otherwise go to FILL.
- `rst_w_index_i` is ignored outside WAIT_ACK. `start_i` is ignored when not IDLE.
- Counter widths: `row_cnt` is `$clog2(W)+1` bits; `tile_cnt` is 16 bits with no wrap inside a job.

## Timing
- `load_o` and `x_data_o` are combinational from the FIFO head and state; the X buffer registers them.
- A beat pushed in cycle t can be loaded in cycle t+1 at the earliest. The FIFO is not fall-through.
- With continuous valid input and `FIFO_DEPTH`≥2, the block sustains one load per cycle.
- The first load can occur in the cycle after `start_i` if the FIFO is non-empty.
- `tile_done_o` is asserted in the same cycle as the accepted `rst_w_index_i`. The first load of the next tile is in the next cycle at the earliest.
- Simultaneous `clear_i` with any event: clear wins.

## Configuration
- `REDMULE_XFEED_LEFTOVER_MASK_EN` defined:
  - element i of `x_data_o` (bits `[i*BITW +: BITW]`) is forced to 0 when i ≥ `elems_q`;
  - elements below `elems_q` pass unchanged.
- `REDMULE_XFEED_LEFTOVER_MASK_EN` undefined:
  - the FIFO head is passed unmodified;
  - `cfg_valid_elems_i` is unused and no mask logic is generated.

## Test plan
- Reset, then idle: `stream_ready_o`=1, `load_o`=0, `busy_o`=0, `x_data_o`=0 for 10 cycles.
- Continuous stream, `cfg_rows_i`=12, `cfg_tiles_i`=2:
  - 12 back-to-back `load_o` cycles, then WAIT_ACK with no loads;
  - `rst_w_index_i` pulse gives `tile_done_o` in the same cycle;
  - 12 more loads, a second ack gives `tile_done_o` and `job_done_o`, then IDLE.
- Backpressure: FIFO full (2 beats prefetched in IDLE) → `stream_ready_o`=0. `start_i` → loads in the next 2 cycles, and `stream_ready_o` returns to 1 after the first pop.
- Mask enabled, `cfg_valid_elems_i`=5, beats all-ones → each `x_data_o` has bits [79:0] set and bits [287:80] zero.
- Mid-tile clear after 5 of 12 loads: next cycle is IDLE, FIFO empty, `stream_ready_o`=1. A new job with `cfg_rows_i`=3 loads exactly 3 rows.
- Clamping and ignores:
  - `cfg_rows_i`=0 loads 12 rows; `cfg_tiles_i`=0 start is ignored (`busy_o` stays 0);
  - `rst_w_index_i` during FILL causes no `tile_done_o`.
